// File: rtl/counter32_capture.sv
// Measures the number of Clk_i cycles between two synchronised rising edges of Event_i.
// Optional continuous back-to-back period capture is enabled by COUNTER32_CAPTURE_CONTINUOUS_EN.
module counter32_capture #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        Clk_i,
    input  logic        Reset_n_i,
    input  logic        Arm_i,
    input  logic        Event_i,
`ifdef COUNTER32_CAPTURE_CONTINUOUS_EN
    input  logic        Continuous_i,
`endif
    output logic [31:0] Value_o,
    output logic        Done_o,
    output logic        Busy_o,
    output logic        Overflow_o
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        COUNTING   = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         count;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     hist_q;
    logic                     edge_s;
    logic                     cont_c;

`ifdef COUNTER32_CAPTURE_CONTINUOUS_EN
    assign cont_c = Continuous_i;
`else
    assign cont_c = 1'b0;
`endif

    // Synchroniser chain plus history flop; every edge sees the same fixed latency
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Event_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_s = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Measurement FSM; Arm_i restarts from any state and wins over a coincident edge
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state      <= IDLE;
            count      <= '0;
            Value_o    <= '0;
            Done_o     <= 1'b0;
            Busy_o     <= 1'b0;
            Overflow_o <= 1'b0;
        end else if (Arm_i) begin
            state      <= WAIT_FIRST;
            count      <= '0;
            Value_o    <= '0;
            Done_o     <= 1'b0;
            Busy_o     <= 1'b1;
            Overflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Busy_o <= 1'b0;
                end
                WAIT_FIRST: begin
                    if (edge_s) begin
                        count <= CNT_ONE;
                        state <= COUNTING;
                    end
                end
                COUNTING: begin
                    Done_o <= 1'b0;
                    if (edge_s) begin
                        Value_o <= count;
                        Done_o  <= 1'b1;
                        if (cont_c) begin
                            // The closing edge is also the opening edge of the next period
                            count <= CNT_ONE;
                        end else begin
                            Busy_o <= 1'b0;
                            state  <= DONE;
                        end
                    end else if (count == CNT_MAX) begin
                        Value_o    <= CNT_MAX;
                        Overflow_o <= 1'b1;
                        Done_o     <= 1'b1;
                        Busy_o     <= 1'b0;
                        state      <= DONE;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                DONE: begin
                    Busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter32_capture.sv
// Directed self-checking bench for counter32_capture (one-shot and, when enabled, continuous mode).
module tb_counter32_capture;

    localparam int unsigned SYNC = 2;

    logic        clk;
    logic        reset_n;
    logic        arm;
    logic        event_i;
    logic        continuous;
    logic [31:0] value;
    logic        done;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    counter32_capture #(.SYNC_STAGES(SYNC)) dut (
        .Clk_i        (clk),
        .Reset_n_i    (reset_n),
        .Arm_i        (arm),
        .Event_i      (event_i),
`ifdef COUNTER32_CAPTURE_CONTINUOUS_EN
        .Continuous_i (continuous),
`endif
        .Value_o      (value),
        .Done_o       (done),
        .Busy_o       (busy),
        .Overflow_o   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; arm = 1'b0; event_i = 1'b0; continuous = 1'b0;
        wait_neg(3);
        checks++; if ({value, done, busy, overflow} !== 35'd0) begin errors++;
            $display("FAIL reset_in got v=%h d=%b b=%b o=%b exp all 0", value, done, busy, overflow); end
        reset_n = 1'b1;
        wait_neg(2);
        checks++; if ({value, done, busy, overflow} !== 35'd0) begin errors++;
            $display("FAIL reset_out got v=%h d=%b b=%b o=%b exp all 0", value, done, busy, overflow); end
    endtask

    task automatic test_idle_events();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); event_i = 1'b1;
            wait_neg(3);    event_i = 1'b0;
            wait_neg(3);
        end
        checks++; if ({value, done, busy, overflow} !== 35'd0) begin errors++;
            $display("FAIL idle_events got v=%h d=%b b=%b o=%b exp all 0", value, done, busy, overflow); end
    endtask

    task automatic test_period_100();
        arm_pulse();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL armed_busy got b=%b d=%b exp b=1 d=0", busy, done); end
        event_i = 1'b1;
        for (int s = 1; s <= 100; s++) begin
            @(negedge clk);
            if (s == 1) event_i = 1'b0;
            if (s == 50) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
                    $display("FAIL mid_busy got b=%b d=%b exp b=1 d=0", busy, done); end
            end
        end
        event_i = 1'b1;
        wait_neg(SYNC);
        event_i = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL pre_done got d=%b b=%b exp d=0 b=1", done, busy); end
        wait_neg(1);
        checks++; if (value !== 32'd100 || done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL period_100 got v=%0d d=%b b=%b o=%b exp v=100 d=1 b=0 o=0", value, done, busy, overflow); end
        for (int e = 0; e < 3; e++) begin
            wait_neg(5); event_i = 1'b1;
            wait_neg(5); event_i = 1'b0;
        end
        wait_neg(6);
        checks++; if (value !== 32'd100 || done !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL hold_100 got v=%0d d=%b b=%b exp v=100 d=1 b=0", value, done, busy); end
    endtask

    task automatic test_min_period();
        arm_pulse();
        event_i = 1'b1;
        @(negedge clk); event_i = 1'b0;
        @(negedge clk); event_i = 1'b1;
        @(negedge clk); event_i = 1'b0;
        wait_neg(SYNC);
        // Pin pattern 1,0,1 yields detected edges two cycles apart
        checks++; if (value !== 32'd2 || done !== 1'b1) begin errors++;
            $display("FAIL min_period got v=%0d d=%b exp v=2 d=1", value, done); end
    endtask

    task automatic test_overflow();
        arm_pulse();
        event_i = 1'b1;
        @(negedge clk); event_i = 1'b0;
        wait_neg(SYNC);
        force dut.count = 32'hFFFF_FFF0;
        #1 release dut.count;
        wait_neg(15);
        checks++; if (overflow !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL ovf_edge got o=%b d=%b b=%b exp o=0 d=0 b=1", overflow, done, busy); end
        wait_neg(1);
        checks++; if (overflow !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || value !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL ovf got o=%b d=%b b=%b v=%h exp o=1 d=1 b=0 v=ffffffff", overflow, done, busy, value); end
        event_i = 1'b1; wait_neg(2); event_i = 1'b0; wait_neg(5);
        checks++; if (overflow !== 1'b1 || value !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL ovf_hold got o=%b v=%h exp o=1 v=ffffffff", overflow, value); end
    endtask

    task automatic test_arm_priority();
        @(negedge clk); event_i = 1'b1;
        wait_neg(SYNC);
        arm = 1'b1;
        @(negedge clk); arm = 1'b0; event_i = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || value !== 32'd0 || overflow !== 1'b0) begin errors++;
            $display("FAIL arm_clear got b=%b d=%b v=%h o=%b exp b=1 d=0 v=0 o=0", busy, done, value, overflow); end
        for (int s = SYNC + 2; s <= 50; s++) @(negedge clk);
        event_i = 1'b1;
        for (int s = 51; s <= 70; s++) begin
            @(negedge clk);
            if (s == 51) event_i = 1'b0;
            if (s == 50 + SYNC + 1) begin
                checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
                    $display("FAIL arm_edge_ignored got d=%b b=%b exp d=0 b=1", done, busy); end
            end
        end
        event_i = 1'b1;
        wait_neg(SYNC + 1);
        event_i = 1'b0;
        checks++; if (value !== 32'd20 || done !== 1'b1) begin errors++;
            $display("FAIL arm_priority got v=%0d d=%b exp v=20 d=1", value, done); end
    endtask

    task automatic test_reset_mid_count();
        arm_pulse();
        event_i = 1'b1;
        wait_neg(10);
        event_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({value, done, busy, overflow} !== 35'd0) begin errors++;
            $display("FAIL async_reset got v=%h d=%b b=%b o=%b exp all 0", value, done, busy, overflow); end
        wait_neg(2); reset_n = 1'b1; wait_neg(4);
        checks++; if ({value, done, busy, overflow} !== 35'd0) begin errors++;
            $display("FAIL post_reset got v=%h d=%b b=%b o=%b exp all 0", value, done, busy, overflow); end
    endtask

`ifdef COUNTER32_CAPTURE_CONTINUOUS_EN
    task automatic test_continuous();
        int per [3];
        int len;
        per[0] = 40; per[1] = 60; per[2] = 25;
        continuous = 1'b1;
        arm_pulse();
        event_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            len = (k < 3) ? per[k] : SYNC + 3;
            for (int s = 1; s <= len; s++) begin
                @(negedge clk);
                if (s == 1) event_i = 1'b0;
                if (k > 0 && s == SYNC + 1) begin
                    checks++; if (done !== 1'b1 || busy !== 1'b1 || value !== 32'(per[k-1])) begin errors++;
                        $display("FAIL cont_pulse%0d got d=%b b=%b v=%0d exp d=1 b=1 v=%0d", k, done, busy, value, per[k-1]); end
                end
                if (k > 0 && s == SYNC + 2) begin
                    checks++; if (done !== 1'b0 || busy !== 1'b1 || value !== 32'(per[k-1])) begin errors++;
                        $display("FAIL cont_drop%0d got d=%b b=%b v=%0d exp d=0 b=1 v=%0d", k, done, busy, value, per[k-1]); end
                end
            end
            if (k < 3) event_i = 1'b1;
        end
        continuous = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_events();
        test_period_100();
        test_min_period();
        test_overflow();
        test_arm_priority();
        test_reset_mid_count();
`ifdef COUNTER32_CAPTURE_CONTINUOUS_EN
        test_continuous();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
